// File: rtl/freqchng_pkg.sv
// Shared definitions for the frequency-change sequencer: state encoding,
// default guard length and the width of the step/select fields.
package freqchng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_DWELL  = 2'd2,
    ST_FINISH = 2'd3
  } freqchng_state_e;

  // Settle cycles after every FREQ_SEL change unless overridden at the top.
  localparam int GUARD_DEFAULT = 4;

  // Step indices and frequency selects are both 3 bits wide.
  localparam int IDX_W = 3;

endpackage

// File: rtl/freqchng_sequencer.sv
// Frequency-change sequencer: walks a small register table of {sel, dwell}
// entries, drives FREQ_SEL to a downstream clock mux, holds a guard period
// after every select change, then dwells for the entry's count.
//
// Strobe semantics: START and ABORT are single-cycle pulses sampled on the
// rising edge of CLK; ABORT wins over START. WR_EN is a write strobe that is
// accepted only while BUSY is low; there is no back-pressure, so a write
// presented while BUSY is high is simply lost.
module freqchng_sequencer
  import freqchng_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16,
  parameter int GUARD   = GUARD_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WR_EN,
  input  logic [IDX_W-1:0]   WR_ADDR,
  input  logic [IDX_W-1:0]   WR_SEL,
  input  logic [DWELL_W-1:0] WR_DWELL,
  input  logic [IDX_W-1:0]   NUM_STEPS,
  input  logic               LOOP,
  input  logic               START,
  input  logic               ABORT,
  output logic [IDX_W-1:0]   FREQ_SEL,
  output logic [IDX_W-1:0]   STEP_IDX,
  output logic               BUSY,
  output logic               SETTLED,
  output logic               CHANGE,
  output logic               DONE,
  output freqchng_state_e    dbg_state
);

  // The shared counter must hold both GUARD-1 (up to 14) and dwell-1.
  localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD - 1);

  logic [IDX_W-1:0]   sel_tab   [DEPTH];
  logic [DWELL_W-1:0] dwell_tab [DEPTH];

  freqchng_state_e  state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] step;

  logic [IDX_W-1:0] num_eff;
  logic             last_step;
  logic [IDX_W-1:0] next_step;
  logic [IDX_W-1:0] next_sel;
  logic [CNT_W-1:0] next_dwell_load;
  logic [CNT_W-1:0] cur_dwell_load;

  // A dwell of 0 behaves like 1, so the counter load is max(d,1)-1.
  function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    if (d == '0) return '0;
    return CNT_W'(d) - CNT_W'(1);
  endfunction

  assign STEP_IDX  = step;
  assign dbg_state = state;

  // Step-boundary decision: NUM_STEPS and LOOP are only consulted here,
  // so changes to them take effect at the next boundary.
  always_comb begin
    num_eff         = (NUM_STEPS > LAST_IDX) ? LAST_IDX : NUM_STEPS;
    last_step       = (step >= num_eff);
    next_step       = last_step ? '0 : step + IDX_W'(1);
    next_sel        = sel_tab[next_step];
    next_dwell_load = dwell_load(dwell_tab[next_step]);
    cur_dwell_load  = dwell_load(dwell_tab[step]);
  end

  // Sequence table: writable only while idle, out-of-range addresses dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        sel_tab[i]   <= '0;
        dwell_tab[i] <= '0;
      end
    end else if (WR_EN && !BUSY && (WR_ADDR <= LAST_IDX)) begin
      sel_tab[WR_ADDR]   <= WR_SEL;
      dwell_tab[WR_ADDR] <= WR_DWELL;
    end
  end

  // Main sequencer FSM with registered outputs and one shared down-counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      step     <= '0;
      FREQ_SEL <= '0;
      BUSY     <= 1'b0;
      SETTLED  <= 1'b0;
      CHANGE   <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      CHANGE <= 1'b0;
      DONE   <= 1'b0;
      if (ABORT) begin
        // FREQ_SEL and step are left as they are; the mux stays put.
        state   <= ST_IDLE;
        cnt     <= '0;
        BUSY    <= 1'b0;
        SETTLED <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (START) begin
              // First load always takes the guard, even for an equal select.
              state    <= ST_SWITCH;
              step     <= '0;
              FREQ_SEL <= sel_tab[0];
              CHANGE   <= (sel_tab[0] != FREQ_SEL);
              cnt      <= GUARD_LOAD;
              BUSY     <= 1'b1;
              SETTLED  <= 1'b0;
            end
          end
          ST_SWITCH: begin
            if (cnt == '0) begin
              state   <= ST_DWELL;
              SETTLED <= 1'b1;
              cnt     <= cur_dwell_load;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_DWELL: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (last_step && !LOOP) begin
              state   <= ST_FINISH;
              BUSY    <= 1'b0;
              SETTLED <= 1'b0;
              DONE    <= 1'b1;
            end else begin
              step     <= next_step;
              FREQ_SEL <= next_sel;
              if (next_sel != FREQ_SEL) begin
                state   <= ST_SWITCH;
                SETTLED <= 1'b0;
                CHANGE  <= 1'b1;
                cnt     <= GUARD_LOAD;
              end else begin
                // Same select: no settling needed, straight into the dwell.
                cnt <= next_dwell_load;
              end
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freqchng_sequencer.sv
// Bench for freqchng_sequencer: directed scenarios plus randomized tables,
// checked cycle by cycle against a trace expanded from the sequencing rules.
module tb_freqchng_sequencer;
  import freqchng_pkg::*;

  localparam int DEPTH   = 6;
  localparam int DWELL_W = 16;
  localparam int GUARD   = 4;
  localparam int W       = 10;

  logic               CLK;
  logic               RST;
  logic               WR_EN;
  logic [2:0]         WR_ADDR;
  logic [2:0]         WR_SEL;
  logic [DWELL_W-1:0] WR_DWELL;
  logic [2:0]         NUM_STEPS;
  logic               LOOP;
  logic               START;
  logic               ABORT;
  logic [2:0]         FREQ_SEL;
  logic [2:0]         STEP_IDX;
  logic               BUSY;
  logic               SETTLED;
  logic               CHANGE;
  logic               DONE;
  freqchng_state_e    dbg_state;

  freqchng_sequencer #(
    .DEPTH  (DEPTH),
    .DWELL_W(DWELL_W),
    .GUARD  (GUARD)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_SEL   (WR_SEL),
    .WR_DWELL (WR_DWELL),
    .NUM_STEPS(NUM_STEPS),
    .LOOP     (LOOP),
    .START    (START),
    .ABORT    (ABORT),
    .FREQ_SEL (FREQ_SEL),
    .STEP_IDX (STEP_IDX),
    .BUSY     (BUSY),
    .SETTLED  (SETTLED),
    .CHANGE   (CHANGE),
    .DONE     (DONE),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cyc;

  // Reference model of the table and the visible outputs between runs.
  int m_sel [8];
  int m_dw  [8];
  int m_fs;
  int m_step;
  int m_num;
  int m_loop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed view: {FREQ_SEL, STEP_IDX, BUSY, SETTLED, CHANGE, DONE}
  function automatic logic [W-1:0] mk(input int fs, input int st, input bit b,
                                      input bit s, input bit c, input bit d);
    return {3'(fs), 3'(st), b, s, c, d};
  endfunction

  function automatic logic [W-1:0] obs();
    return {FREQ_SEL, STEP_IDX, BUSY, SETTLED, CHANGE, DONE};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_sel[i] = 0;
      m_dw[i]  = 0;
    end
    m_fs   = 0;
    m_step = 0;
  endfunction

  // Expand the sequencing rules into the per-cycle trace starting at cycle 1.
  task automatic build_trace(input int max_len);
    int  step;
    int  fs;
    int  numc;
    int  d;
    bit  first;
    bit  chg;
    exp_q.delete();
    numc  = (m_num > DEPTH - 1) ? DEPTH - 1 : m_num;
    step  = 0;
    fs    = m_fs;
    first = 1'b1;
    while (exp_q.size() < max_len) begin
      if (first || m_sel[step] != fs) begin
        chg = (m_sel[step] != fs);
        fs  = m_sel[step];
        for (int g = 0; g < GUARD; g++) exp_q.push_back(mk(fs, step, 1, 0, chg && (g == 0), 0));
      end
      d = (m_dw[step] == 0) ? 1 : m_dw[step];
      for (int k = 0; k < d; k++) exp_q.push_back(mk(fs, step, 1, 1, 0, 0));
      first = 1'b0;
      if (step < numc) step++;
      else if (m_loop != 0) step = 0;
      else begin
        exp_q.push_back(mk(fs, step, 0, 0, 0, 1));
        exp_q.push_back(mk(fs, step, 0, 0, 0, 0));
        break;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    model_clear();
    check_eq("reset_outputs", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0)));
    check_eq("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    RST = 1'b0;
  endtask

  task automatic write_entry(input int addr, input int sel, input int dw);
    WR_EN    = 1'b1;
    WR_ADDR  = 3'(addr);
    WR_SEL   = 3'(sel);
    WR_DWELL = DWELL_W'(dw);
    @(negedge CLK);
    WR_EN = 1'b0;
    if (addr < DEPTH) begin
      m_sel[addr] = sel;
      m_dw[addr]  = dw;
    end
  endtask

  // stop_kind: 0 run to completion, 1 ABORT in cycle stop_at, 2 RST in cycle stop_at.
  // noise: while busy, throw in ignored START pulses and dropped writes.
  task automatic run_seq(input int max_len, input int stop_at, input int stop_kind, input bit noise);
    logic [W-1:0] e;
    logic [W-1:0] e_stop;
    int idx;
    build_trace(max_len);
    done_cyc  = -1;
    NUM_STEPS = 3'(m_num);
    LOOP      = m_loop[0];
    START     = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    idx   = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idx++;
      check_eq($sformatf("seq_cycle%0d", idx), 32'(obs()), 32'(e));
      if (DONE) done_cyc = idx;
      m_fs   = int'(e[9:7]);
      m_step = int'(e[6:4]);
      if (idx == stop_at && stop_kind == 1) ABORT = 1'b1;
      else if (idx == stop_at && stop_kind == 2) RST = 1'b1;
      else if (noise && e[3]) begin
        START    = 1'($urandom_range(0, 1));
        WR_EN    = 1'($urandom_range(0, 1));
        WR_ADDR  = 3'($urandom_range(0, 7));
        WR_SEL   = 3'($urandom_range(0, 7));
        WR_DWELL = DWELL_W'($urandom_range(0, 9));
      end
      @(negedge CLK);
      START = 1'b0;
      WR_EN = 1'b0;
      if (idx == stop_at && stop_kind != 0) begin
        ABORT = 1'b0;
        RST   = 1'b0;
        if (stop_kind == 2) begin
          model_clear();
          e_stop = mk(0, 0, 0, 0, 0, 0);
        end else begin
          e_stop = mk(m_fs, m_step, 0, 0, 0, 0);
        end
        check_eq("stop_outputs", 32'(obs()), 32'(e_stop));
        check_eq("stop_state", 32'(dbg_state), 32'(ST_IDLE));
        break;
      end
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_wr;
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_SEL = '0; WR_DWELL = '0;
    NUM_STEPS = '0; LOOP = 1'b0; START = 1'b0; ABORT = 1'b0;
    m_num = 0; m_loop = 0;
    model_clear();
    reset_dut();

    // Basic two-step run with a select change at each step.
    write_entry(0, 1, 3);
    write_entry(1, 2, 2);
    m_num = 1; m_loop = 0;
    run_seq(100, 0, 0, 1'b0);
    check_eq("basic_done_cycle", 32'(done_cyc), 32'd14);
    check_eq("basic_end_sel", 32'(FREQ_SEL), 32'd2);

    // Equal selects: second step skips the guard.
    write_entry(0, 3, 2);
    write_entry(1, 3, 2);
    run_seq(100, 0, 0, 1'b0);
    check_eq("same_sel_done_cycle", 32'(done_cyc), 32'd9);

    // Looping: never finishes, stopped by ABORT.
    write_entry(0, 1, 3);
    write_entry(1, 2, 2);
    m_loop = 1;
    run_seq(40, 40, 1, 1'b1);
    check_eq("loop_no_done", 32'(done_cyc), 32'hffff_ffff);

    // Abort in cycle 6 of the basic run, then a clean restart.
    m_loop = 0;
    run_seq(100, 6, 1, 1'b0);
    check_eq("abort_hold_sel", 32'(FREQ_SEL), 32'd1);
    @(negedge CLK);
    check_eq("abort_no_done", 32'(DONE), 32'd0);
    run_seq(100, 0, 0, 1'b0);

    // START and ABORT together while idle: stays idle.
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    check_eq("start_abort_outputs", 32'(obs()), 32'(mk(m_fs, m_step, 0, 0, 0, 0)));
    check_eq("start_abort_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge CLK);
    check_eq("start_abort_later", 32'(dbg_state), 32'(ST_IDLE));

    // Zero dwell plus writes hammered while busy.
    write_entry(0, 5, 0);
    write_entry(1, 6, 1);
    write_entry(2, 6, 0);
    m_num = 2;
    run_seq(100, 0, 0, 1'b1);
    run_seq(100, 0, 0, 1'b0);

    // Reset mid-sequence clears outputs and the table.
    write_entry(0, 1, 3);
    write_entry(1, 2, 2);
    m_num = 1;
    run_seq(100, 10, 2, 1'b0);
    run_seq(100, 0, 0, 1'b0);

    // Out-of-range address and NUM_STEPS clamp.
    write_entry(6, 7, 9);
    write_entry(7, 7, 9);
    for (int i = 0; i < DEPTH; i++) write_entry(i, i + 1, 1);
    m_num = 7;
    run_seq(200, 0, 0, 1'b0);

    // Randomized tables and controls.
    for (int r = 0; r < 25; r++) begin
      n_wr = $urandom_range(0, 5);
      for (int k = 0; k < n_wr; k++)
        write_entry($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 5));
      m_num  = $urandom_range(0, 7);
      m_loop = $urandom_range(0, 1);
      if (m_loop != 0) run_seq(80, $urandom_range(3, 80), 1, 1'b1);
      else if ($urandom_range(0, 3) == 0) run_seq(120, $urandom_range(1, 20), 1, 1'b1);
      else run_seq(200, 0, 0, 1'b1);
      @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freqchng_sequencer.md
FREQCHNG_SEQUENCER -- requirements
Module: freqchng_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of sequence table entries (2..8).
REQ-002 SHALL have parameter DWELL_W, default 16: width of the per-step dwell count.
REQ-003 SHALL have parameter GUARD, default 4: number of settle cycles after each FREQ_SEL change (1..15).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port WR_EN, input, 1 bit: write strobe for one sequence table entry.
REQ-007 SHALL have port WR_ADDR, input, 3 bits: index of the table entry to write.
REQ-008 SHALL have port WR_SEL, input, 3 bits: frequency select value for that entry.
REQ-009 SHALL have port WR_DWELL, input, DWELL_W bits: dwell length of that entry, in CLK cycles.
REQ-010 SHALL have port NUM_STEPS, input, 3 bits: index of the last active step (steps 0..NUM_STEPS are active).
REQ-011 SHALL have port LOOP, input, 1 bit: 1 = after the last step, restart at step 0.
REQ-012 SHALL have port START, input, 1 bit: pulse that begins the sequence.
REQ-013 SHALL have port ABORT, input, 1 bit: pulse that stops the sequence.
REQ-014 SHALL have port FREQ_SEL, output, 3 bits, registered: drives the select input of the downstream clock mux.
REQ-015 SHALL have port STEP_IDX, output, 3 bits: index of the current step.
REQ-016 SHALL have port BUSY, output, 1 bit: high in SWITCH and DWELL.
REQ-017 SHALL have port SETTLED, output, 1 bit: high only in DWELL.
REQ-018 SHALL have port CHANGE, output, 1 bit: one-cycle pulse in the first cycle a new FREQ_SEL value is driven.
REQ-019 SHALL have port DONE, output, 1 bit: one-cycle pulse when a non-looping sequence completes.

Function
REQ-020 SHALL store DEPTH entries of {sel, dwell}.
REQ-021 SHALL write an entry only when WR_EN=1 and BUSY=0; a write attempted while BUSY=1 is dropped.
REQ-022 SHALL ignore WR_ADDR values of DEPTH or more, and SHALL clamp NUM_STEPS to DEPTH-1.
REQ-023 SHALL implement exactly four states: IDLE, SWITCH, DWELL, FINISH.
REQ-024 In IDLE, START=1 SHALL, in the next cycle, set step=0, load FREQ_SEL from entry 0 and enter SWITCH.
REQ-025 SWITCH SHALL last exactly GUARD cycles with SETTLED=0, then enter DWELL.
REQ-026 DWELL SHALL last max(dwell,1) cycles with SETTLED=1; a dwell value of 0 is treated as 1.
REQ-027 At the end of DWELL, when step<NUM_STEPS, the block SHALL advance step by 1 and load the next entry.
REQ-028 At the end of DWELL, when step=NUM_STEPS and LOOP=1, the block SHALL wrap to step 0 and load entry 0.
REQ-029 At the end of DWELL, when step=NUM_STEPS and LOOP=0, the block SHALL enter FINISH.
REQ-030 When a newly loaded sel differs from the current FREQ_SEL, the block SHALL assert CHANGE and go through SWITCH.
REQ-031 When a newly loaded sel equals the current FREQ_SEL, the block SHALL skip SWITCH, go directly to DWELL and leave CHANGE low.
REQ-032 The first load after START SHALL always go through SWITCH, and SHALL assert CHANGE only if the sel value differs.
REQ-033 FINISH SHALL last one cycle with DONE=1 and BUSY=0, then return to IDLE.
REQ-034 ABORT=1 in any state SHALL force IDLE in the next cycle, with no DONE pulse and FREQ_SEL holding its last value.
REQ-035 When START and ABORT are both high in the same cycle, ABORT SHALL take priority.
REQ-036 START while BUSY=1 SHALL be ignored.
REQ-037 LOOP and NUM_STEPS SHALL be sampled at each step boundary, so a change takes effect at the next boundary.
REQ-038 FREQ_SEL SHALL change only on state-machine load events, never combinationally.

Reset
REQ-039 RST=1 SHALL force: state IDLE; FREQ_SEL=0; STEP_IDX=0; BUSY, SETTLED, CHANGE and DONE all 0; all counters 0; all table entries {0,0}.
REQ-040 RST asserted mid-sequence SHALL take effect at the next edge, overriding START and ABORT.

Structure
REQ-041 The state encoding and the GUARD default SHALL be placed in shared package freqchng_pkg.
REQ-042 The table SHALL be implemented as registers.
REQ-043 The block SHALL use a single down-counter shared by SWITCH and DWELL; no sub-module is required.

Verification
REQ-044 GUARD=4; table {1,3},{2,2}; NUM_STEPS=1; LOOP=0; START in cycle 0 -> FREQ_SEL=1 and CHANGE=1 in cycle 1; SETTLED=0 in cycles 1-4 and 1 in cycles 5-7; FREQ_SEL=2 and CHANGE=1 in cycle 8; SETTLED=1 in cycles 12-13; DONE=1 and BUSY=0 in cycle 14.
REQ-045 Table {3,2},{3,2}; NUM_STEPS=1 -> step 1 has no SWITCH and no CHANGE pulse; DWELL of step 1 directly follows DWELL of step 0.
REQ-046 LOOP=1 with the REQ-044 table -> after step 1, FREQ_SEL returns to 1 with CHANGE=1; no DONE pulse; BUSY stays high.
REQ-047 ABORT in cycle 6 of the REQ-044 run -> IDLE in cycle 7; FREQ_SEL stays 1; DONE never pulses; a following START restarts from step 0.
REQ-048 WR_EN while BUSY, START plus ABORT in the same cycle, and dwell=0 -> the write is dropped (table read-back unchanged); the block stays IDLE; that step dwells 1 cycle.
REQ-049 RST in cycle 10 of a running sequence -> all outputs 0 in cycle 11 and the table is cleared.
